lu_row_buffer: RTL
==================

Name: lu_row_buffer

Overview:
- Matrix row store that sits directly upstream of the LU decomposition engine (lu) and serves its row-read / row-write-back interface.
- The host streams a SIZE x SIZE complex double matrix in row by row. The buffer then pulses start to lu, answers its row reads with 1-cycle latency and absorbs its in-place row updates.
- When lu drops busy, the buffer streams the updated matrix back out to the host.
- Each row is SIZE complex elements; each element is {imag, real} with every part WIDTH-bit IEEE-754.

Parameters:
- SIZE, 4, matrix dimension (rows, and complex elements per row).
- WIDTH, 64, bits per real or imaginary part.
- AW, $clog2(SIZE), row address width (derived; do not override).

Ports:
- clk_i  in  1  clock. One clock domain.
- rst_ni  in  1  reset. Synchronous, active-low.
- flush_i  in  1  abort: return to LOAD.
- load_row_i  in  SIZE*2*WIDTH  host row. Element j occupies bits [j*2*WIDTH +: 2*WIDTH], real part in the low WIDTH bits.
- load_valid_i  in  1  host row valid.
- load_ready_o  out  1  buffer accepts host row.
- lu_start_o  out  1  one-cycle start pulse to lu.start.
- lu_busy_i  in  1  from lu.busy_o.
- mat_row_read_addr_i  in  AW  from lu.mat_row_read_addr_o.
- mat_row_read_addr_valid_i  in  1  from lu.mat_row_read_addr_valid_o.
- mat_row_o  out  SIZE*2*WIDTH  to lu.mat_row_i.
- mat_row_valid_o  out  1  to lu.mat_row_valid_i.
- mat_row_addr_o  out  AW  to lu.mat_row_read_addr_i (echo of the served address).
- wr_row_i  in  SIZE*2*WIDTH  from lu.mat_row_o.
- wr_valid_i  in  1  from lu.mat_row_valid_o.
- wr_addr_i  in  AW  from lu.mat_row_write_addr_o.
- wr_ready_o  out  1  to lu.mat_row_out_ready_i.
- drain_row_o  out  SIZE*2*WIDTH  result row to host.
- drain_addr_o  out  AW  index of the row on drain_row_o.
- drain_valid_o  out  1  result row valid.
- drain_ready_i  in  1  host accepts result row.
- busy_o  out  1  high in RUN and DRAIN.
- err_o  out  1  sticky protocol error.

Behaviour:
- Storage: SIZE registers of SIZE*2*WIDTH bits. Contents are not reset or cleared by flush.
- Reset (rst_ni=0 at a clock edge):
  - State goes to LOAD; row counter = 0.
  - All outputs are 0 except load_ready_o=1.
- State LOAD:
  - load_ready_o=1.
  - Handshake is load_valid_i & load_ready_o; each one writes row[cnt] and increments cnt.
  - On the handshake with cnt==SIZE-1: cnt clears to 0, go to RUN.
- State RUN:
  - lu_start_o=1 in the first RUN cycle only.
  - wr_ready_o=1 for the whole of RUN.
  - Read: when mat_row_read_addr_valid_i=1 in cycle N, then in cycle N+1:
    - mat_row_o = row[addr], sampled at cycle N before any same-cycle write (read-before-write);
    - mat_row_addr_o = addr;
    - mat_row_valid_o = 1.
  - Otherwise mat_row_valid_o=0 and mat_row_o holds its last value.
  - Write: wr_valid_i=1 writes row[wr_addr_i] at the edge. A read issued in the following cycle returns the new data.
  - Busy tracking: flag seen_busy is set when lu_busy_i=1. Leave for DRAIN when seen_busy=1 and lu_busy_i=0; clear seen_busy on exit.
  - A write coinciding with the exit cycle is still committed.
- State DRAIN:
  - drain_valid_o=1, drain_row_o=row[cnt], drain_addr_o=cnt.
  - Each drain_valid_o & drain_ready_i increments cnt.
  - While drain_ready_i=0, data and address stay stable.
  - After the handshake with cnt==SIZE-1: cnt clears to 0, go to LOAD.
- Outside RUN: wr_ready_o=0 and mat_row_valid_o=0. Read requests and writes are ignored and set err_o.
- err_o is also set in any state when an address >= SIZE is presented with its valid (only possible for non-power-of-2 SIZE); that access is ignored. err_o clears only on reset.
- flush_i=1 (any state, highest priority after reset):
  - Next state LOAD; cnt=0; seen_busy=0.
  - mat_row_valid_o, drain_valid_o and lu_start_o forced to 0 next cycle.
  - Any load, write or drain handshake in the flush cycle is discarded.
- Reset or flush mid-operation discards partial loads and drains. The host must reload all SIZE rows.

Test Plan:
- Load rows 0..3, where row i, element j is real=i*4+j, imag=-(i*4+j) -> load_ready_o drops after the 4th beat; lu_start_o is high exactly one cycle later; busy_o=1.
- In RUN, request addr 2 in cycle N -> in cycle N+1 mat_row_valid_o=1, mat_row_addr_o=2, mat_row_o = row 2 as loaded.
- Same-cycle read and write to addr 1 with new data D -> next cycle returns the old row 1; a read one cycle later returns D.
- Hold lu_busy_i=1 for 10 cycles, then 0 -> enter DRAIN; rows 0..3 emitted in order. With drain_ready_i toggling 1,0,1,0 the data holds during stalls; then back to LOAD with load_ready_o=1.
- Assert flush_i in the middle of RUN, with reads outstanding -> next cycle state LOAD, mat_row_valid_o=0, and no lu_start_o until 4 new rows are loaded.
- Assert wr_valid_i during LOAD -> row contents unchanged, err_o=1 and held until rst_ni=0.

Source files
------------

// File: rtl/lu_row_buffer.sv
// Row store in front of the LU engine: loads a SIZE x SIZE complex matrix from the host,
// serves the engine's row reads and write-backs, then drains the result to the host.
module lu_row_buffer #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [SIZE*2*WIDTH-1:0] load_row_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  output logic                    lu_start_o,
  input  logic                    lu_busy_i,
  input  logic [AW-1:0]           mat_row_read_addr_i,
  input  logic                    mat_row_read_addr_valid_i,
  output logic [SIZE*2*WIDTH-1:0] mat_row_o,
  output logic                    mat_row_valid_o,
  output logic [AW-1:0]           mat_row_addr_o,
  input  logic [SIZE*2*WIDTH-1:0] wr_row_i,
  input  logic                    wr_valid_i,
  input  logic [AW-1:0]           wr_addr_i,
  output logic                    wr_ready_o,
  output logic [SIZE*2*WIDTH-1:0] drain_row_o,
  output logic [AW-1:0]           drain_addr_o,
  output logic                    drain_valid_o,
  input  logic                    drain_ready_i,
  output logic                    busy_o,
  output logic                    err_o
);
  localparam int ROW_W = SIZE*2*WIDTH;
  localparam logic [AW-1:0] LAST   = AW'(SIZE-1);
  localparam logic [AW:0]   SIZE_W = (AW+1)'(SIZE);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_e;

  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic seen_q, seen_d, start_q, start_d, err_q, err_d;
  logic rd_vld_q, rd_vld_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [ROW_W-1:0] rd_row_q, rd_row_d;
  logic ld_we, lu_we, rd_ok, wr_ok;
  logic [SIZE-1:0][ROW_W-1:0] rows_q;

  assign rd_ok = {1'b0, mat_row_read_addr_i} < SIZE_W;
  assign wr_ok = {1'b0, wr_addr_i} < SIZE_W;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seen_d    = seen_q;
    start_d   = 1'b0;
    err_d     = err_q;
    rd_vld_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_row_d  = rd_row_q;
    ld_we     = 1'b0;
    lu_we     = 1'b0;
    if ((mat_row_read_addr_valid_i && !rd_ok) || (wr_valid_i && !wr_ok)) err_d = 1'b1;
    case (state_q)
      S_LOAD: begin
        if (mat_row_read_addr_valid_i || wr_valid_i) err_d = 1'b1;
        if (load_valid_i) begin
          ld_we = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_RUN;
            start_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        // Read samples the pre-edge contents, so a same-cycle write is not visible yet.
        if (mat_row_read_addr_valid_i && rd_ok) begin
          rd_vld_d  = 1'b1;
          rd_addr_d = mat_row_read_addr_i;
          rd_row_d  = rows_q[mat_row_read_addr_i];
        end
        lu_we = wr_valid_i && wr_ok;
        if (lu_busy_i) seen_d = 1'b1;
        if (seen_q && !lu_busy_i) begin
          state_d = S_DRAIN;
          seen_d  = 1'b0;
        end
      end
      S_DRAIN: begin
        if (mat_row_read_addr_valid_i || wr_valid_i) err_d = 1'b1;
        if (drain_ready_i) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    if (flush_i) begin
      state_d  = S_LOAD;
      cnt_d    = '0;
      seen_d   = 1'b0;
      start_d  = 1'b0;
      rd_vld_d = 1'b0;
      rd_row_d = rd_row_q;
      ld_we    = 1'b0;
      lu_we    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      seen_q    <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_row_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      start_q   <= start_d;
      err_q     <= err_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      rd_row_q  <= rd_row_d;
    end
  end

  // Row storage is deliberately left out of reset and flush.
  for (genvar r = 0; r < SIZE; r++) begin : g_row
    always_ff @(posedge clk_i) begin
      if (ld_we && cnt_q == AW'(r))
        rows_q[r] <= load_row_i;
      else if (lu_we && wr_addr_i == AW'(r))
        rows_q[r] <= wr_row_i;
    end
  end

  assign load_ready_o    = state_q == S_LOAD;
  assign wr_ready_o      = state_q == S_RUN;
  assign busy_o          = state_q != S_LOAD;
  assign lu_start_o      = start_q;
  assign err_o           = err_q;
  assign mat_row_o       = rd_row_q;
  assign mat_row_addr_o  = rd_addr_q;
  assign mat_row_valid_o = rd_vld_q && state_q == S_RUN;
  assign drain_valid_o   = state_q == S_DRAIN;
  assign drain_addr_o    = drain_valid_o ? cnt_q : '0;
  assign drain_row_o     = drain_valid_o ? rows_q[cnt_q] : '0;
endmodule
